// File: rtl/instr_fetch_unit.sv
// Fetch stage: takes a PC over valid/ready, issues one instruction-memory request at a time,
// and presents the returned word (tagged with its PC) through a one-entry output buffer.
module instr_fetch_unit #(
   parameter bit          ALIGN_CHECK = 1'b1,
   parameter logic [31:0] FAULT_WORD  = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc_in,
   input  logic        pc_valid,
   output logic        pc_ready,
   input  logic        flush,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        inst_fault,
   input  logic        inst_ready,
   output logic [31:0] fetch_count
);

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StHold,
      StDrain
   } state_t;

   state_t      state;
   logic [31:0] addr;
   logic        accept;
   logic        misaligned;
   logic        deliver;

   always_comb begin
      pc_ready       = !reset && !flush &&
                       ((state == StIdle) || ((state == StHold) && inst_ready));
      accept         = pc_valid && pc_ready;
      misaligned     = ALIGN_CHECK && (pc_in[1:0] != 2'b00);
      deliver        = (state == StHold) && inst_ready && !flush;
      imem_req_valid = (state == StReq);
      imem_req_addr  = addr;
      inst_valid     = (state == StHold);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= StIdle;
         addr        <= '0;
         inst_data   <= '0;
         inst_pc     <= '0;
         inst_fault  <= 1'b0;
         fetch_count <= '0;
      end else begin
         unique case (state)
            StIdle: state <= StIdle;
            StReq: begin
               if (flush) begin
                  state <= StIdle;
               end else if (imem_req_ready) begin
                  state <= StWait;
               end
            end
            StWait: begin
               if (imem_resp_valid) begin
                  // A response landing with a flush is stale and must not reach decode.
                  if (flush) begin
                     state <= StIdle;
                  end else begin
                     state      <= StHold;
                     inst_data  <= imem_resp_data;
                     inst_pc    <= addr;
                     inst_fault <= 1'b0;
                  end
               end else if (flush) begin
                  state <= StDrain;
               end
            end
            StDrain: begin
               if (imem_resp_valid) begin
                  state <= StIdle;
               end
            end
            StHold: begin
               if (flush || inst_ready) begin
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase

         // A new accept overrides the case above, giving back-to-back issue out of HOLD.
         if (accept) begin
            if (misaligned) begin
               state      <= StHold;
               inst_fault <= 1'b1;
               inst_data  <= FAULT_WORD;
               inst_pc    <= pc_in;
            end else begin
               state <= StReq;
               addr  <= {pc_in[31:2], 2'b00};
            end
         end

         if (deliver) begin
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: hand-computed expectations checked with immediate
// assertions, covering latency, streaming, flush in every busy state and misaligned fetches.
module tb_instr_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] pc_in;
   logic        pc_valid;
   logic        pc_ready;
   logic        flush;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_fault;
   logic        inst_ready;
   logic [31:0] fetch_count;

   int pass_count = 0;
   int total      = 0;
   int stale_seen = 0;
   int proto_err  = 0;

   instr_fetch_unit #(
      .ALIGN_CHECK(1'b1),
      .FAULT_WORD (32'h0000_0000)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .pc_in          (pc_in),
      .pc_valid       (pc_valid),
      .pc_ready       (pc_ready),
      .flush          (flush),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_fault     (inst_fault),
      .inst_ready     (inst_ready),
      .fetch_count    (fetch_count)
   );

   always #5 clock = ~clock;

   // Stale data must never be presented as a valid instruction.
   always @(negedge clock) begin
      if (inst_valid && inst_data == 32'hDEAD_BEEF) stale_seen++;
      // A response is only legal while a request is outstanding (WAIT or DRAIN).
      if (!reset && imem_resp_valid && (imem_req_valid || inst_valid || pc_ready)) proto_err++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_count++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset           = 1'b1;
      pc_in           = '0;
      pc_valid        = 1'b0;
      flush           = 1'b0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      inst_ready      = 1'b0;
      cyc();
      cyc();
      check("rst_pc_ready", pc_ready, 0);
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_count", fetch_count, 0);
      reset = 1'b0;
      #1;
      check("post_rst_pc_ready", pc_ready, 1);

      // 1: single fetch, zero-wait memory
      pc_in = 32'h0000_3000; pc_valid = 1'b1; imem_req_ready = 1'b1;
      cyc();
      pc_valid = 1'b0;
      #1;
      check("t1_req_valid", imem_req_valid, 1);
      check("t1_req_addr", imem_req_addr, 32'h0000_3000);
      check("t1_pc_ready_busy", pc_ready, 0);
      cyc();
      imem_resp_valid = 1'b1; imem_resp_data = 32'h2408_0005;
      #1;
      check("t1_req_dropped", imem_req_valid, 0);
      check("t1_not_yet_valid", inst_valid, 0);
      cyc();
      imem_resp_valid = 1'b0;
      check("t1_inst_valid", inst_valid, 1);
      check("t1_inst_data", inst_data, 32'h2408_0005);
      check("t1_inst_pc", inst_pc, 32'h0000_3000);
      check("t1_inst_fault", inst_fault, 0);
      inst_ready = 1'b1;
      cyc();
      inst_ready = 1'b0;
      check("t1_count", fetch_count, 1);
      check("t1_idle", inst_valid, 0);

      // 2: stream three PCs back to back with decode always ready
      inst_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pc_in = 32'h0000_3000 + 32'(4 * i); pc_valid = 1'b1;
         #1;
         check("t2_pc_ready", pc_ready, 1);
         if (i > 0) begin
            check("t2_hold_valid", inst_valid, 1);
            check("t2_hold_data", inst_data, 32'h0000_1000 + 32'(i - 1));
            check("t2_hold_pc", inst_pc, 32'h0000_3000 + 32'(4 * (i - 1)));
         end
         cyc();
         pc_valid = 1'b0;
         check("t2_no_bubble", imem_req_valid, 1);
         check("t2_addr", imem_req_addr, 32'h0000_3000 + 32'(4 * i));
         cyc();
         imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_1000 + 32'(i);
         cyc();
         imem_resp_valid = 1'b0;
      end
      check("t2_last_data", inst_data, 32'h0000_1002);
      check("t2_last_pc", inst_pc, 32'h0000_3008);
      cyc();
      inst_ready = 1'b0;
      check("t2_count", fetch_count, 4);
      check("t2_idle", inst_valid, 0);

      // 3: memory stalls in REQ, then flush withdraws the request
      pc_in = 32'h0000_5000; pc_valid = 1'b1; imem_req_ready = 1'b0;
      cyc();
      pc_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("t3_req_held", imem_req_valid, 1);
         check("t3_addr_stable", imem_req_addr, 32'h0000_5000);
         cyc();
      end
      flush = 1'b1;
      #1;
      check("t3_flush_pc_ready", pc_ready, 0);
      cyc();
      flush = 1'b0;
      #1;
      check("t3_withdrawn", imem_req_valid, 0);
      check("t3_pc_ready", pc_ready, 1);
      check("t3_no_inst", inst_valid, 0);

      // 4: flush in WAIT, stale response arrives later and is dropped
      pc_in = 32'h0000_6000; pc_valid = 1'b1; imem_req_ready = 1'b1;
      cyc();
      pc_valid = 1'b0;
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0; pc_in = 32'h0000_4000; pc_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("t4_drain_pc_ready", pc_ready, 0);
         check("t4_drain_no_req", imem_req_valid, 0);
         cyc();
      end
      imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
      #1;
      check("t4_stale_pc_ready", pc_ready, 0);
      cyc();
      imem_resp_valid = 1'b0;
      #1;
      check("t4_drained_pc_ready", pc_ready, 1);
      check("t4_dropped", inst_valid, 0);
      cyc();
      pc_valid = 1'b0;
      check("t4_new_addr", imem_req_addr, 32'h0000_4000);
      cyc();
      imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0000;
      cyc();
      imem_resp_valid = 1'b0;
      check("t4_valid", inst_valid, 1);
      check("t4_data", inst_data, 32'h0000_0000);
      check("t4_pc", inst_pc, 32'h0000_4000);
      inst_ready = 1'b1;
      cyc();
      inst_ready = 1'b0;
      check("t4_count", fetch_count, 5);

      // 5: misaligned PC faults without touching memory
      pc_in = 32'h0000_3002; pc_valid = 1'b1;
      cyc();
      pc_valid = 1'b0;
      check("t5_no_req", imem_req_valid, 0);
      check("t5_valid", inst_valid, 1);
      check("t5_fault", inst_fault, 1);
      check("t5_data", inst_data, 32'h0000_0000);
      check("t5_pc", inst_pc, 32'h0000_3002);

      // 6: stall in HOLD, then flush and pc_valid together; flush wins
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("t6_stall_valid", inst_valid, 1);
         check("t6_stall_pc", inst_pc, 32'h0000_3002);
         check("t6_stall_fault", inst_fault, 1);
         check("t6_stall_no_req", imem_req_valid, 0);
      end
      flush = 1'b1; pc_valid = 1'b1; pc_in = 32'h0000_7000; inst_ready = 1'b1;
      #1;
      check("t6_flush_pc_ready", pc_ready, 0);
      cyc();
      flush = 1'b0; pc_valid = 1'b0; inst_ready = 1'b0;
      check("t6_cleared", inst_valid, 0);
      check("t6_no_req", imem_req_valid, 0);
      check("t6_count", fetch_count, 5);

      // Reset mid-transaction clears the request and the counter
      pc_in = 32'h0000_8000; pc_valid = 1'b1;
      cyc();
      pc_valid = 1'b0;
      check("rst2_req", imem_req_valid, 1);
      reset = 1'b1;
      cyc();
      check("rst2_req_drop", imem_req_valid, 0);
      check("rst2_count", fetch_count, 0);
      reset = 1'b0;
      #1;
      check("rst2_pc_ready", pc_ready, 1);

      check("no_stale_data", 32'(stale_seen), 0);
      check("no_protocol_error", 32'(proto_err), 0);

      $display("%0d/%0d checks passed", pass_count, total);
      $finish;
   end

endmodule
